lcd_digit_overlay: RTL and testbench



---
 rtl/lcd_overlay_pkg.sv | 26 ++
 rtl/lcd_glyph_rom.sv | 65 ++++++
 rtl/lcd_digit_overlay.sv | 139 +++++++++++++
 tb/tb_lcd_digit_overlay.sv | 362 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_overlay_pkg.sv
// Shared constants and stage bundle for the LCD numeric overlay.
// Optional blink support is enabled with LCD_DIGIT_BLINK_EN.
package lcd_overlay_pkg;

    localparam int CELL_W = 16;
    localparam int CELL_H = 32;

    localparam logic [3:0] CODE_MINUS = 4'hA;
    localparam logic [3:0] CODE_COLON = 4'hB;
    localparam logic [3:0] CODE_BLANK = 4'hF;

    localparam logic [23:0] WHITE = 24'hFFFFFF;
    localparam logic [23:0] BLACK = 24'h000000;

    typedef struct packed {
        logic       hit;
        logic [3:0] code;
        logic [3:0] col;
        logic [4:0] row;
    } ovl_s1_t;

    function automatic int slot_count(input int n, input int sep);
        return n + ((sep != 0) ? 1 : 0);
    endfunction

endpackage

// File: rtl/lcd_glyph_rom.sv
// 16x32 glyph bitmaps built from seven-segment style bars.
// Bit [15] of a row is the leftmost pixel.
module lcd_glyph_rom
    import lcd_overlay_pkg::*;
(
    input  logic [3:0]  code,
    input  logic [4:0]  row,
    output logic [15:0] bits
);

    localparam logic [15:0] H_BAR = 16'h3FFC;
    localparam logic [15:0] L_BAR = 16'h3800;
    localparam logic [15:0] R_BAR = 16'h001C;
    localparam logic [15:0] C_BAR = 16'h03C0;

    // seg = {a, b, c, d, e, f, g}
    logic [6:0] seg;
    logic       r_top;
    logic       r_mid;
    logic       r_bot;
    logic       r_upper;
    logic       r_lower;
    logic       r_stem;
    logic       r_dots;

    always_comb begin
        case (code)
            4'h0:       seg = 7'b1111110;
            4'h2:       seg = 7'b1101101;
            4'h3:       seg = 7'b1111001;
            4'h4:       seg = 7'b0110011;
            4'h5:       seg = 7'b1011011;
            4'h6:       seg = 7'b1011111;
            4'h7:       seg = 7'b1110000;
            4'h8:       seg = 7'b1111111;
            4'h9:       seg = 7'b1111011;
            CODE_MINUS: seg = 7'b0000001;
            default:    seg = 7'b0000000;
        endcase
    end

    assign r_top   = (row >= 5'd2)  && (row <= 5'd4);
    assign r_mid   = (row >= 5'd15) && (row <= 5'd17);
    assign r_bot   = (row >= 5'd27) && (row <= 5'd29);
    assign r_upper = (row >= 5'd3)  && (row <= 5'd16);
    assign r_lower = (row >= 5'd15) && (row <= 5'd28);
    assign r_stem  = (row >= 5'd2)  && (row <= 5'd29);
    assign r_dots  = ((row >= 5'd8)  && (row <= 5'd11)) ||
                     ((row >= 5'd20) && (row <= 5'd23));

    always_comb begin
        bits = '0;
        if (seg[6] && r_top)   bits = bits | H_BAR;
        if (seg[5] && r_upper) bits = bits | R_BAR;
        if (seg[4] && r_lower) bits = bits | R_BAR;
        if (seg[3] && r_bot)   bits = bits | H_BAR;
        if (seg[2] && r_lower) bits = bits | L_BAR;
        if (seg[1] && r_upper) bits = bits | L_BAR;
        if (seg[0] && r_mid)   bits = bits | H_BAR;
        // '1' is a centred stem so it reads well at small sizes
        if ((code == 4'h1) && r_stem)       bits = bits | C_BAR;
        if ((code == CODE_COLON) && r_dots) bits = bits | C_BAR;
    end

endmodule

// File: rtl/lcd_digit_overlay.sv
// Two-stage numeric text overlay with per-frame value snapshot.
// Define LCD_DIGIT_BLINK_EN to add per-digit blinking.
module lcd_digit_overlay
    import lcd_overlay_pkg::*;
#(
    parameter int          NUM_DIGITS = 8,
    parameter logic [10:0] POS_X      = 11'd1,
    parameter logic [10:0] POS_Y      = 11'd1,
    parameter int          SCALE_LOG2 = 0,
    parameter int          SEP_POS    = 4,
    parameter logic [23:0] FG_COLOR   = BLACK,
    parameter logic [23:0] BG_COLOR   = WHITE
) (
    input  logic                    lcd_pclk,
    input  logic                    sys_rst_n,
    input  logic                    frame_start,
    input  logic [4*NUM_DIGITS-1:0] data,
    input  logic                    lz_blank,
`ifdef LCD_DIGIT_BLINK_EN
    input  logic [NUM_DIGITS-1:0]   blink_mask,
`endif
    input  logic [10:0]             pixel_xpos,
    input  logic [10:0]             pixel_ypos,
    output logic [23:0]             pixel_data,
    output logic                    in_region
);

    localparam int S     = SCALE_LOG2;
    localparam int SLOTS = slot_count(NUM_DIGITS, SEP_POS);
    localparam int X_END = int'(POS_X) + SLOTS * (CELL_W << S);
    localparam int Y_END = int'(POS_Y) + (CELL_H << S);

    localparam logic [11:0] X_HI     = 12'(X_END);
    localparam logic [11:0] Y_HI     = 12'(Y_END);
    localparam logic [4:0]  SEP_SLOT = 5'(SEP_POS);
    localparam bit          SEP_EN   = (SEP_POS != 0);

    logic [4*NUM_DIGITS-1:0] shadow;
    logic [NUM_DIGITS-1:0]   lz_mask;
    logic [NUM_DIGITS-1:0]   lz_next;
`ifdef LCD_DIGIT_BLINK_EN
    logic [7:0]              frame_cnt;
    logic [NUM_DIGITS-1:0]   blink_sh;
`endif

    // lz_next[i] marks digit i (from the MSB) as part of the zero run
    always_comb begin : lz_scan
        logic run;
        lz_next = '0;
        run     = lz_blank;
        for (int i = 0; i < NUM_DIGITS - 1; i++) begin
            run        = run && (data[4*(NUM_DIGITS-1-i) +: 4] == 4'h0);
            lz_next[i] = run;
        end
    end

    always_ff @(posedge lcd_pclk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            shadow    <= '0;
            lz_mask   <= '0;
`ifdef LCD_DIGIT_BLINK_EN
            frame_cnt <= '0;
            blink_sh  <= '0;
`endif
        end else if (frame_start) begin
            shadow    <= data;
            lz_mask   <= lz_next;
`ifdef LCD_DIGIT_BLINK_EN
            frame_cnt <= frame_cnt + 8'd1;
            blink_sh  <= blink_mask;
`endif
        end
    end

    logic [10:0] dx;
    logic [10:0] dy;
    logic        x_in;
    logic        y_in;
    logic [4:0]  slot;
    logic [4:0]  didx;
    logic        sep_slot;
    logic [3:0]  nib;
    logic        blank;
    logic        unused_dxy;
    ovl_s1_t     s1_d;
    ovl_s1_t     s1_q;

    assign dx         = pixel_xpos - POS_X;
    assign dy         = pixel_ypos - POS_Y;
    assign x_in       = (pixel_xpos >= POS_X) && ({1'b0, pixel_xpos} < X_HI);
    assign y_in       = (pixel_ypos >= POS_Y) && ({1'b0, pixel_ypos} < Y_HI);
    assign slot       = dx[8+S:4+S];
    assign sep_slot   = SEP_EN && (slot == SEP_SLOT);
    assign unused_dxy = ^{dx, dy};

    always_comb begin
        didx = slot;
        if (SEP_EN && (slot > SEP_SLOT)) didx = slot - 5'd1;
        nib   = CODE_BLANK;
        blank = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (didx == 5'(i)) begin
                nib   = shadow[4*(NUM_DIGITS-1-i) +: 4];
                blank = lz_mask[i];
`ifdef LCD_DIGIT_BLINK_EN
                blank = blank | (frame_cnt[5] & blink_sh[NUM_DIGITS-1-i]);
`endif
            end
        end
        s1_d.hit  = x_in && y_in;
        s1_d.code = (sep_slot || blank) ? CODE_BLANK : nib;
        s1_d.col  = dx[3+S:S];
        s1_d.row  = dy[4+S:S];
    end

    logic [15:0] glyph_bits;

    lcd_glyph_rom u_rom (
        .code (s1_q.code),
        .row  (s1_q.row),
        .bits (glyph_bits)
    );

    always_ff @(posedge lcd_pclk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            s1_q       <= '0;
            in_region  <= 1'b0;
            pixel_data <= BG_COLOR;
        end else begin
            s1_q      <= s1_d;
            in_region <= s1_q.hit;
            if (s1_q.hit && glyph_bits[4'd15 - s1_q.col])
                pixel_data <= FG_COLOR;
            else
                pixel_data <= BG_COLOR;
        end
    end

endmodule

// File: tb/tb_lcd_digit_overlay.sv
// Bench for lcd_digit_overlay: two instances (1x and 2x scale) vs a model.
// Covers LCD_DIGIT_BLINK_EN when that macro is defined.
module tb_lcd_digit_overlay;
    import lcd_overlay_pkg::*;

    localparam logic [23:0] RED  = 24'hFF0000;
    localparam logic [23:0] BLUE = 24'h0000FF;

    logic        lcd_pclk    = 1'b0;
    logic        sys_rst_n   = 1'b1;
    logic        frame_start = 1'b0;
    logic        lz_blank    = 1'b0;
    logic [31:0] data        = '0;
    logic [10:0] pixel_xpos  = '0;
    logic [10:0] pixel_ypos  = '0;
    logic [23:0] pixel_data0;
    logic [23:0] pixel_data1;
    logic        in_region0;
    logic        in_region1;
`ifdef LCD_DIGIT_BLINK_EN
    logic [7:0]  blink_mask = '0;
    bit   [7:0]  nxt_blink  = '0;
    bit   [7:0]  m_blink    = '0;
`endif

    always #5 lcd_pclk = ~lcd_pclk;

    lcd_digit_overlay #(
        .NUM_DIGITS(8), .POS_X(11'd1), .POS_Y(11'd1),
        .SCALE_LOG2(0), .SEP_POS(4),
        .FG_COLOR(BLACK), .BG_COLOR(WHITE)
    ) dut0 (
        .lcd_pclk    (lcd_pclk),
        .sys_rst_n   (sys_rst_n),
        .frame_start (frame_start),
        .data        (data),
        .lz_blank    (lz_blank),
`ifdef LCD_DIGIT_BLINK_EN
        .blink_mask  (blink_mask),
`endif
        .pixel_xpos  (pixel_xpos),
        .pixel_ypos  (pixel_ypos),
        .pixel_data  (pixel_data0),
        .in_region   (in_region0)
    );

    lcd_digit_overlay #(
        .NUM_DIGITS(8), .POS_X(11'd20), .POS_Y(11'd10),
        .SCALE_LOG2(1), .SEP_POS(4),
        .FG_COLOR(RED), .BG_COLOR(BLUE)
    ) dut1 (
        .lcd_pclk    (lcd_pclk),
        .sys_rst_n   (sys_rst_n),
        .frame_start (frame_start),
        .data        (data),
        .lz_blank    (lz_blank),
`ifdef LCD_DIGIT_BLINK_EN
        .blink_mask  (blink_mask),
`endif
        .pixel_xpos  (pixel_xpos),
        .pixel_ypos  (pixel_ypos),
        .pixel_data  (pixel_data1),
        .in_region   (in_region1)
    );

    typedef struct {
        logic [23:0] p0;
        logic        r0;
        logic [23:0] p1;
        logic        r1;
        int          lit;
        logic [23:0] lp;
        logic        lr;
        string       nm;
    } exp_t;

    typedef struct {
        int          x;
        int          y;
        logic [23:0] pix;
        logic        rg;
        string       nm;
    } probe_t;

    exp_t   pipe[$];
    probe_t probes[$];

    int        n_cmp   = 0;
    int        n_bad   = 0;
    bit [31:0] nxt_data = '0;
    bit        nxt_lz   = 1'b0;
    bit [31:0] m_data   = '0;
    bit        m_lz     = 1'b0;
    int        m_cnt    = 0;

    function automatic bit box(int c, int r, int c0, int c1, int r0, int r1);
        return (c >= c0) && (c <= c1) && (r >= r0) && (r <= r1);
    endfunction

    // Font as rectangles on a 16x32 grid
    function automatic bit glyph_on(int code, int c, int r);
        bit [6:0] s;
        case (code)
            0:       s = 7'b1111110;
            2:       s = 7'b1101101;
            3:       s = 7'b1111001;
            4:       s = 7'b0110011;
            5:       s = 7'b1011011;
            6:       s = 7'b1011111;
            7:       s = 7'b1110000;
            8:       s = 7'b1111111;
            9:       s = 7'b1111011;
            10:      s = 7'b0000001;
            default: s = 7'b0000000;
        endcase
        if (code == 1) return box(c, r, 6, 9, 2, 29);
        if (code == 11)
            return box(c, r, 6, 9, 8, 11) || box(c, r, 6, 9, 20, 23);
        return (s[6] && box(c, r, 2, 13, 2, 4))
            || (s[5] && box(c, r, 11, 13, 3, 16))
            || (s[4] && box(c, r, 11, 13, 15, 28))
            || (s[3] && box(c, r, 2, 13, 27, 29))
            || (s[2] && box(c, r, 2, 4, 15, 28))
            || (s[1] && box(c, r, 2, 4, 3, 16))
            || (s[0] && box(c, r, 2, 13, 15, 17));
    endfunction

    function automatic int digit_of(int i);
        return int'((m_data >> (4 * (7 - i))) & 32'hF);
    endfunction

    function automatic void model(input int inst, input int x, input int y,
                                  output logic [23:0] pix, output logic rg);
        int px, py, s, cw, ch, slot, col, row, di, nlz;
        logic [23:0] fg, bg;
        px = inst ? 20 : 1;
        py = inst ? 10 : 1;
        s  = inst ? 1 : 0;
        fg = inst ? RED : BLACK;
        bg = inst ? BLUE : WHITE;
        cw = 16 << s;
        ch = 32 << s;
        rg = (x >= px) && (x < px + 9 * cw) && (y >= py) && (y < py + ch);
        pix = bg;
        if (!rg) return;
        slot = (x - px) / cw;
        col  = ((x - px) >> s) % 16;
        row  = (y - py) >> s;
        if (slot == 4) return;
        di = (slot > 4) ? slot - 1 : slot;
        nlz = 0;
        while (nlz < 7 && digit_of(nlz) == 0) nlz++;
        if (m_lz && di < nlz) return;
`ifdef LCD_DIGIT_BLINK_EN
        if (((m_cnt / 32) % 2 == 1) && m_blink[7 - di]) return;
`endif
        if (glyph_on(digit_of(di), col, row)) pix = fg;
    endfunction

    task automatic cmp(input string nm, input logic [23:0] gp, input logic gr,
                       input logic [23:0] wp, input logic wr);
        n_cmp++;
        if (gp !== wp || gr !== wr) begin
            n_bad++;
            $display("FAIL %s: got pix=%h reg=%0b, want pix=%h reg=%0b",
                     nm, gp, gr, wp, wr);
        end
    endtask

    task automatic check(input exp_t e);
        cmp("model_dut0", pixel_data0, in_region0, e.p0, e.r0);
        cmp("model_dut1", pixel_data1, in_region1, e.p1, e.r1);
        if (e.lit == 1) cmp(e.nm, pixel_data0, in_region0, e.lp, e.lr);
        if (e.lit == 2) cmp(e.nm, pixel_data1, in_region1, e.lp, e.lr);
    endtask

    task automatic step(input int x, input int y, input bit fs,
                        input int lit = 0, input logic [23:0] lp = '0,
                        input logic lr = 1'b0, input string nm = "");
        exp_t e;
        @(negedge lcd_pclk);
        if (pipe.size() == 2) check(pipe.pop_front());
        pixel_xpos  = 11'(x);
        pixel_ypos  = 11'(y);
        frame_start = fs;
        data        = nxt_data;
        lz_blank    = nxt_lz;
`ifdef LCD_DIGIT_BLINK_EN
        blink_mask  = nxt_blink;
`endif
        model(0, x, y, e.p0, e.r0);
        model(1, x, y, e.p1, e.r1);
        e.lit = lit;
        e.lp  = lp;
        e.lr  = lr;
        e.nm  = nm;
        pipe.push_back(e);
        if (fs) begin
            m_data = nxt_data;
            m_lz   = nxt_lz;
`ifdef LCD_DIGIT_BLINK_EN
            m_blink = nxt_blink;
`endif
            m_cnt = (m_cnt + 1) % 256;
        end
    endtask

    task automatic do_reset();
        @(negedge lcd_pclk);
        sys_rst_n   = 1'b0;
        frame_start = 1'b0;
        #1;
        cmp("reset_dut0", pixel_data0, in_region0, WHITE, 1'b0);
        cmp("reset_dut1", pixel_data1, in_region1, BLUE, 1'b0);
        pipe.delete();
        m_data = '0;
        m_lz   = 1'b0;
        m_cnt  = 0;
`ifdef LCD_DIGIT_BLINK_EN
        m_blink = '0;
`endif
        @(negedge lcd_pclk);
        @(negedge lcd_pclk);
        sys_rst_n = 1'b1;
    endtask

    task automatic add_probe(input int x, input int y, input logic [23:0] p,
                             input logic rg, input string nm);
        probe_t pr;
        pr.x = x; pr.y = y; pr.pix = p; pr.rg = rg; pr.nm = nm;
        probes.push_back(pr);
    endtask

    task automatic scan();
        for (int y = 0; y < 35; y++) begin
            for (int x = 0; x < 150; x++) begin
                int          lit;
                logic [23:0] lp;
                logic        lr;
                string       nm;
                lit = 0; lp = '0; lr = 1'b0; nm = "";
                foreach (probes[i]) begin
                    if (probes[i].x == x && probes[i].y == y) begin
                        lit = 1;
                        lp  = probes[i].pix;
                        lr  = probes[i].rg;
                        nm  = probes[i].nm;
                    end
                end
                step(x, y, 1'b0, lit, lp, lr, nm);
            end
        end
    endtask

    function automatic bit [31:0] rand_digits();
        bit [31:0] r;
        for (int i = 0; i < 8; i++)
            r[4*i +: 4] = ($urandom_range(0, 2) == 0) ? 4'h0
                        : 4'($urandom_range(0, 15));
        return r;
    endfunction

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        do_reset();

        // first frame after reset shows zeros whatever data says
        nxt_data = 32'hDEAD_BEEF;
        add_probe(3, 11, BLACK, 1'b1, "zero_after_reset");
        add_probe(1, 1, WHITE, 1'b1, "top_left_in");
        add_probe(144, 32, WHITE, 1'b1, "bottom_right_in");
        add_probe(0, 11, WHITE, 1'b0, "left_edge_out");
        add_probe(145, 11, WHITE, 1'b0, "right_edge_out");
        add_probe(3, 33, WHITE, 1'b0, "bottom_edge_out");
        scan();

        probes.delete();
        nxt_data = 32'h1234_5678;
        step(0, 0, 1'b1);
        add_probe(8, 17, BLACK, 1'b1, "digit1_inside");
        add_probe(65, 11, WHITE, 1'b1, "sep_left_col");
        add_probe(80, 20, WHITE, 1'b1, "sep_right_col");
        scan();

        // new data without frame_start must not show up
        probes.delete();
        nxt_data = 32'h8888_8888;
        add_probe(7, 6, BLACK, 1'b1, "hold_until_fs");
        scan();
        step(7, 6, 1'b1, 1, BLACK, 1'b1, "fs_same_cycle_old");
        step(7, 6, 1'b0, 1, WHITE, 1'b1, "fs_next_cycle_new");

        probes.delete();
        nxt_data = 32'h0000_0070;
        nxt_lz   = 1'b1;
        step(0, 0, 1'b1);
        add_probe(3, 11, WHITE, 1'b1, "lz_msb_blank");
        add_probe(99, 11, WHITE, 1'b1, "lz_d5_blank");
        add_probe(124, 11, BLACK, 1'b1, "lz_seven_shown");
        add_probe(131, 11, BLACK, 1'b1, "lz_zero_shown");
        scan();

        probes.delete();
        nxt_data = 32'h0;
        step(0, 0, 1'b1);
        add_probe(115, 11, WHITE, 1'b1, "lz_all_d6_blank");
        add_probe(131, 11, BLACK, 1'b1, "lz_lsd_kept");
        scan();

        // 2x instance: 2x2 blocks and right edge at POS_X+288
        nxt_data = 32'h1234_5678;
        nxt_lz   = 1'b0;
        step(0, 0, 1'b1);
        step(32, 42, 1'b0, 2, RED, 1'b1, "x2_block_00");
        step(33, 42, 1'b0, 2, RED, 1'b1, "x2_block_10");
        step(32, 43, 1'b0, 2, RED, 1'b1, "x2_block_01");
        step(33, 43, 1'b0, 2, RED, 1'b1, "x2_block_11");
        step(31, 42, 1'b0, 2, BLUE, 1'b1, "x2_block_left");
        step(307, 42, 1'b0, 2, BLUE, 1'b1, "x2_last_col_in");
        step(308, 42, 1'b0, 2, BLUE, 1'b0, "x2_right_out");
        step(20, 74, 1'b0, 2, BLUE, 1'b0, "x2_bottom_out");

        for (int c = 0; c < 20000; c++) begin
            bit fs;
            if ($urandom_range(0, 7) == 0) nxt_data = rand_digits();
            if (c == 10000) do_reset();
            fs = ($urandom_range(0, 149) == 0);
            if (fs) begin
                nxt_lz = 1'($urandom_range(0, 1));
`ifdef LCD_DIGIT_BLINK_EN
                nxt_blink = 8'($urandom_range(0, 255));
`endif
            end
            step(int'($urandom_range(0, 320)), int'($urandom_range(0, 80)), fs);
        end
        step(0, 0, 1'b0);
        step(0, 0, 1'b0);

`ifdef LCD_DIGIT_BLINK_EN
        do_reset();
        nxt_data  = 32'h0;
        nxt_lz    = 1'b0;
        nxt_blink = 8'h01;
        for (int k = 0; k < 96; k++) begin
            if (k > 0) step(0, 0, 1'b1);
            step(131, 11, 1'b0, 1,
                 ((k % 64) >= 32) ? WHITE : BLACK, 1'b1, "blink_lsd");
        end
        step(0, 0, 1'b0);
        step(0, 0, 1'b0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
